// File: rtl/ysyx_24090003_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24090003_pkg
//  Description : Shared types and constants for the ysyx_24090003 core slice.
//                Holds the IFU state encoding, bus widths, the default reset
//                PC and the canonical RV32I NOP (addi x0, x0, 0).
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_24090003_pkg;

    localparam int          INST_W           = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    // Fetch unit states. S_HALT is terminal until reset.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } ifu_state_t;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage : ysyx_24090003_pkg
`default_nettype wire

// File: rtl/ysyx_24090003_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24090003_ifu
//  Description : Instruction fetch unit. Holds the architectural PC, keeps at
//                most one fetch outstanding on the imem request channel and
//                hands {inst, pc} to decode over a valid/ready handshake.
//                Accepts PC redirects from execute and latches a sticky fault
//                on bus error, misaligned redirect or fetch timeout.
//  Ports       : cpu_clk / cpu_rst         clock, synchronous active-high reset
//                imem_req_*                fetch request channel (addr = pc)
//                imem_resp_*               fetch response (data, err)
//                ifu_valid/ready/inst/pc   instruction output to decode
//                redirect_valid/pc         PC change request from execute
//                fetch_fault               sticky fault, cleared by reset only
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_24090003_ifu
    import ysyx_24090003_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,

    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INST_W-1:0]  imem_resp_data,
    input  logic               imem_resp_err,

    output logic               ifu_valid,
    input  logic               ifu_ready,
    output logic [INST_W-1:0]  ifu_inst,
    output logic [ADDR_W-1:0]  ifu_pc,

    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,

    output logic               fetch_fault
);

    // A zero timeout disables the watchdog; keep the counter at least 1 bit.
    localparam int WDT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WDT_W-1:0] c_wdt_last = WDT_W'(TIMEOUT_CYC - 1);

    ifu_state_t         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_kill;
    logic [INST_W-1:0]  r_inst;
    logic [WDT_W-1:0]   r_wdt;

    ifu_state_t         w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               w_kill_nxt;
    logic [INST_W-1:0]  w_inst_nxt;
    logic [WDT_W-1:0]   w_wdt_nxt;

    logic               w_redir_bad;
    logic               w_redir_ok;
    logic               w_req_fire;
    logic               w_out_fire;
    logic               w_timeout;

    assign w_redir_bad = redirect_valid && is_misaligned(redirect_pc);
    assign w_redir_ok  = redirect_valid && !is_misaligned(redirect_pc);
    assign w_req_fire  = (r_state == S_REQ) && imem_req_ready;
    assign w_out_fire  = (r_state == S_OUT) && ifu_ready;
    assign w_timeout   = (TIMEOUT_CYC != 0) && (r_wdt == c_wdt_last);

    // Outputs depend on registered state only.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign ifu_valid      = (r_state == S_OUT);
    assign ifu_inst       = r_inst;
    assign ifu_pc         = r_pc;
    assign fetch_fault    = (r_state == S_HALT);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_inst  <= '0;
            r_wdt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            r_inst  <= w_inst_nxt;
            r_wdt   <= w_wdt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_inst_nxt  = r_inst;
        w_wdt_nxt   = r_wdt;

        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                    w_wdt_nxt   = '0;
                    // The old request is already in flight; its response
                    // must be discarded when it arrives.
                    if (w_redir_ok) begin
                        w_kill_nxt = 1'b1;
                        w_pc_nxt   = redirect_pc;
                    end
                end else if (w_redir_ok) begin
                    w_pc_nxt = redirect_pc;
                end
            end

            S_WAIT: begin
                w_wdt_nxt = r_wdt + WDT_W'(1);
                if (imem_resp_valid) begin
                    if (w_redir_ok) begin
                        // Response and redirect together: drop the data and
                        // refetch from the new target straight away.
                        w_pc_nxt    = redirect_pc;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (imem_resp_err) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_inst_nxt  = imem_resp_data;
                        w_state_nxt = S_OUT;
                    end
                end else begin
                    if (w_redir_ok) begin
                        w_pc_nxt   = redirect_pc;
                        w_kill_nxt = 1'b1;
                    end
                    if (w_timeout) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end

            S_OUT: begin
                // A redirect wins over a coinciding handshake; execute is
                // responsible for squashing the instruction decode took.
                if (w_redir_ok) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (w_out_fire) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_HALT;
            end
        endcase

        // A misaligned target is fatal and never reaches the PC.
        if ((r_state != S_HALT) && w_redir_bad) begin
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
        end
    end

endmodule : ysyx_24090003_ifu
`default_nettype wire

// File: tb/tb_ysyx_24090003_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24090003_ifu
//  Description : Directed self-checking bench for the instruction fetch unit.
//                The imem side is driven by hand from each scenario task.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_24090003_ifu;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [31:0] ifu_inst;
    logic [31:0] ifu_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int n_vec = 0;
    int n_err = 0;

    ysyx_24090003_ifu #(
        .RESET_PC    (32'h8000_0000),
        .TIMEOUT_CYC (8)
    ) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst         (cpu_rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .ifu_valid       (ifu_valid),
        .ifu_ready       (ifu_ready),
        .ifu_inst        (ifu_inst),
        .ifu_pc          (ifu_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_fault     (fetch_fault)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_rst         = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        ifu_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        tick();
        tick();
        cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (imem_req_valid !== 1'b1) begin
            n_err++; $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid);
        end
        n_vec++;
        if (imem_req_addr !== 32'h8000_0000) begin
            n_err++; $display("FAIL reset_req_addr: got %h expected 80000000", imem_req_addr);
        end
        n_vec++;
        if ({ifu_valid, fetch_fault} !== 2'b00) begin
            n_err++; $display("FAIL reset_valid_fault: got %b expected 00", {ifu_valid, fetch_fault});
        end
        n_vec++;
        if (ifu_inst !== 32'h0 || ifu_pc !== 32'h8000_0000) begin
            n_err++; $display("FAIL reset_out: got inst %h pc %h expected 00000000 80000000", ifu_inst, ifu_pc);
        end
    endtask

    task automatic test_basic_fetch();
        imem_req_ready = 1'b1;
        tick();                                  // request accepted
        imem_req_ready = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b0 || ifu_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_wait: got req %b valid %b expected 0 0", imem_req_valid, ifu_valid);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        tick();                                  // response captured
        imem_resp_valid = 1'b0;
        n_vec++;
        if (ifu_valid !== 1'b1 || ifu_inst !== 32'h0050_0093 || ifu_pc !== 32'h8000_0000) begin
            n_err++; $display("FAIL basic_out: got v %b inst %h pc %h expected 1 00500093 80000000", ifu_valid, ifu_inst, ifu_pc);
        end
        ifu_ready = 1'b1;
        tick();
        ifu_ready = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || ifu_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_next: got req %b addr %h v %b expected 1 80000004 0", imem_req_valid, imem_req_addr, ifu_valid);
        end
    endtask

    task automatic test_backpressure();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0113;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ifu_valid !== 1'b1 || ifu_inst !== 32'h0010_0113 || ifu_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v %b inst %h pc %h req %b expected 1 00100113 80000004 0", i, ifu_valid, ifu_inst, ifu_pc, imem_req_valid);
            end
            tick();
        end
        n_vec++;
        if (ifu_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_still_valid: got %b expected 1", ifu_valid);
        end
        ifu_ready = 1'b1;
        tick();
        ifu_ready = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
            n_err++; $display("FAIL bp_release: got req %b addr %h expected 1 80000008", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (ifu_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL redir_wait[%0d]: got v %b req %b expected 0 0", i, ifu_valid, imem_req_valid);
            end
            tick();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        n_vec++;
        if (ifu_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            n_err++; $display("FAIL redir_drop: got v %b req %b addr %h expected 0 1 80000100", ifu_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_killed_err();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();                                  // accept and redirect together
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL kill_inflight: got req %b expected 0", imem_req_valid);
        end
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        n_vec++;
        if (fetch_fault !== 1'b0 || ifu_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
            n_err++; $display("FAIL kill_err: got f %b v %b req %b addr %h expected 0 0 1 80000200", fetch_fault, ifu_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_bus_err();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        n_vec++;
        if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || ifu_valid !== 1'b0) begin
            n_err++; $display("FAIL buserr_fault: got f %b req %b v %b expected 1 0 0", fetch_fault, imem_req_valid, ifu_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_vec++;
        if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8000_0200) begin
            n_err++; $display("FAIL buserr_sticky: got f %b req %b addr %h expected 1 0 80000200", fetch_fault, imem_req_valid, imem_req_addr);
        end
        do_reset();
        n_vec++;
        if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            n_err++; $display("FAIL buserr_clear: got f %b req %b addr %h expected 0 1 80000000", fetch_fault, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_timeout();
        imem_req_ready = 1'b1;
        tick();                                  // accept edge
        imem_req_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_vec++;
            if (fetch_fault !== 1'b0) begin
                n_err++; $display("FAIL timeout_early[%0d]: got %b expected 0", i, fetch_fault);
            end
        end
        tick();
        n_vec++;
        if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL timeout_fault: got f %b req %b expected 1 0", fetch_fault, imem_req_valid);
        end
        do_reset();
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        n_vec++;
        if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8000_0000) begin
            n_err++; $display("FAIL misalign: got f %b req %b addr %h expected 1 0 80000000", fetch_fault, imem_req_valid, imem_req_addr);
        end
        do_reset();
    endtask

    task automatic test_wrap_and_redirect_out();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();                                  // redirect without accept
        redirect_valid = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_redir: got req %b addr %h expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        tick();
        imem_resp_valid = 1'b0;
        n_vec++;
        if (ifu_valid !== 1'b1 || ifu_pc !== 32'hFFFF_FFFC || ifu_inst !== 32'h0000_0013) begin
            n_err++; $display("FAIL wrap_out: got v %b pc %h inst %h expected 1 fffffffc 00000013", ifu_valid, ifu_pc, ifu_inst);
        end
        ifu_ready = 1'b1;
        tick();
        ifu_ready = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
            n_err++; $display("FAIL wrap_next: got req %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_0193;
        tick();
        imem_resp_valid = 1'b0;
        ifu_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h8000_0040;
        tick();                                  // handshake and redirect together
        ifu_ready      = 1'b0;
        redirect_valid = 1'b0;
        n_vec++;
        if (ifu_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0040) begin
            n_err++; $display("FAIL out_redir: got v %b req %b addr %h expected 0 1 80000040", ifu_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_reset_in_out();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0030_0213;
        tick();
        imem_resp_valid = 1'b0;
        n_vec++;
        if (ifu_valid !== 1'b1 || ifu_pc !== 32'h8000_0040) begin
            n_err++; $display("FAIL rstout_pre: got v %b pc %h expected 1 80000040", ifu_valid, ifu_pc);
        end
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        n_vec++;
        if (ifu_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || ifu_inst !== 32'h0) begin
            n_err++; $display("FAIL rstout_post: got v %b req %b addr %h inst %h expected 0 1 80000000 00000000", ifu_valid, imem_req_valid, imem_req_addr, ifu_inst);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_wait();
        test_killed_err();
        test_bus_err();
        test_timeout();
        test_misaligned();
        test_wrap_and_redirect_out();
        test_reset_in_out();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ysyx_24090003_ifu
`default_nettype wire
